// File: rtl/xy_seq_pkg.sv
// -----------------------------------------------------------------------------
// xy_seq_pkg
// Shared types and helpers for the x ##d y stimulus driver.
//   xy_state_e : driver FSM state encoding (IDLE, X, GAP, Y)
//   DEF_*_W    : default field widths used by the driver and its sub-module
//   sat_inc    : saturating increment, clamps at max_value instead of wrapping
// -----------------------------------------------------------------------------
package xy_seq_pkg;

  localparam int DEF_DELAY_W = 4;
  localparam int DEF_CNT_W   = 8;
  localparam int DEF_TOT_W   = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    X    = 2'd1,
    GAP  = 2'd2,
    Y    = 2'd3
  } xy_state_e;

  // Width-agnostic up to 32 bits; callers zero-extend and pass their all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/xy_seq_driver_gap_counter.sv
// -----------------------------------------------------------------------------
// xy_gap_counter
// Loadable down-counter that times the idle cycles between x and y.
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset, clears the count
//   load       : load load_value (has priority over dec)
//   dec        : decrement by one; holds at zero rather than wrapping
//   load_value : value to load
//   count      : current count
//   zero       : count == 0
// -----------------------------------------------------------------------------
module xy_gap_counter
  import xy_seq_pkg::*;
#(
  parameter int W = DEF_DELAY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic [W-1:0] count,
  output logic         zero
);

  assign zero = (count == '0);

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order races.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && !zero) begin
      count <= count - W'(1);
    end
  end

endmodule

// File: rtl/xy_seq_driver.sv
// -----------------------------------------------------------------------------
// xy_seq_driver
// Stimulus driver for an `x ##d y` sequence property. Each accepted request
// emits req_count repetitions of "x pulse, then y pulse exactly d cycles later"
// where d = max(req_delay, 1). All outputs are registered.
//
// Configuration macro:
//   XY_SEQ_OVERLAP_EN : when defined, the next repetition's x is issued in the
//                       same cycle as the current y, so each repetition after
//                       the first costs d cycles instead of d+1.
//
// Ports:
//   clk        : clock, all logic on posedge
//   rst        : synchronous active-high reset; abandons any sequence in flight
//   req_valid  : request present
//   req_ready  : driver idle and able to accept (high only in IDLE)
//   req_delay  : cycles from x to y (0 treated as 1), sampled at handshake
//   req_count  : number of repetitions (0 is a no-op), sampled at handshake
//   x, y       : sequence elements, one-cycle pulses
//   busy       : FSM not in IDLE
//   done       : one-cycle pulse when a request completes (with last y)
//   seq_total  : saturating count of x..y pairs emitted since reset
// -----------------------------------------------------------------------------
module xy_seq_driver
  import xy_seq_pkg::*;
#(
  parameter int DELAY_W = DEF_DELAY_W,
  parameter int CNT_W   = DEF_CNT_W,
  parameter int TOT_W   = DEF_TOT_W   // sat_inc limits this to 32 bits
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DELAY_W-1:0] req_delay,
  input  logic [CNT_W-1:0]   req_count,
  output logic               x,
  output logic               y,
  output logic               busy,
  output logic               done,
  output logic [TOT_W-1:0]   seq_total
);

`ifdef XY_SEQ_OVERLAP_EN
  localparam bit OVERLAP = 1'b1;
`else
  localparam bit OVERLAP = 1'b0;
`endif

  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  xy_state_e          state;
  xy_state_e          next_state;
  logic [DELAY_W-1:0] d_q;        // latched delay, always >= 1 once loaded
  logic [CNT_W-1:0]   rem_q;      // repetitions still owed, decremented on y
  logic               handshake;
  logic               enter_y;    // this edge moves the FSM into Y
  logic               gap_load;
  logic               gap_dec;
  logic               gap_zero;
  logic [DELAY_W-1:0] gap_count;
  logic               d_is_one;

  assign handshake = req_valid && req_ready;
  assign d_is_one  = (d_q == DELAY_W'(1));

  // The gap counter is loaded with d-1 in the x cycle; GAP then lasts d-1
  // cycles so that y lands exactly d cycles after x.
  xy_gap_counter #(
    .W (DELAY_W)
  ) u_gap (
    .clk        (clk),
    .rst        (rst),
    .load       (gap_load),
    .dec        (gap_dec),
    .load_value (d_q - DELAY_W'(1)),
    .count      (gap_count),
    .zero       (gap_zero)
  );

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    next_state = state;
    enter_y    = 1'b0;
    gap_load   = 1'b0;
    gap_dec    = 1'b0;
    unique case (state)
      IDLE: begin
        if (handshake && (req_count != '0)) next_state = X;
      end
      X: begin
        if (d_is_one) begin
          next_state = Y;
          enter_y    = 1'b1;
        end else begin
          next_state = GAP;
          gap_load   = 1'b1;
        end
      end
      GAP: begin
        gap_dec = 1'b1;
        // gap_zero only guards against a counter that was never loaded.
        if ((gap_count == DELAY_W'(1)) || gap_zero) begin
          next_state = Y;
          enter_y    = 1'b1;
        end
      end
      Y: begin
        // rem_q was already decremented on entry to Y.
        if (rem_q == '0) begin
          next_state = IDLE;
        end else if (OVERLAP) begin
          // x of the next repetition is emitted alongside this y.
          if (d_is_one) begin
            next_state = Y;
            enter_y    = 1'b1;
          end else begin
            next_state = GAP;
            gap_load   = 1'b1;
          end
        end else begin
          next_state = X;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the latched request fields are reset too, so a request abandoned
    // by reset cannot leak its delay or count into the next one.
    if (rst) begin
      state     <= IDLE;
      d_q       <= '0;
      rem_q     <= '0;
      x         <= 1'b0;
      y         <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      req_ready <= 1'b0;
      seq_total <= '0;
    end else begin
      state <= next_state;

      if (handshake) begin
        d_q   <= (req_delay == '0) ? DELAY_W'(1) : req_delay;
        rem_q <= req_count;
      end else if (enter_y) begin
        rem_q <= rem_q - CNT_W'(1);
      end

      // Outputs are computed from the next state so they line up with it.
      x         <= (next_state == X) || (OVERLAP && enter_y && (rem_q > CNT_W'(1)));
      y         <= enter_y;
      done      <= (handshake && (req_count == '0)) || (enter_y && (rem_q == CNT_W'(1)));
      busy      <= (next_state != IDLE);
      req_ready <= (next_state == IDLE);

      if (enter_y) begin
        seq_total <= TOT_W'(sat_inc(32'(seq_total), 32'(TOT_MAX)));
      end
    end
  end

endmodule
